// File: rtl/predecode_queue_pkg.sv
// Shared types, opcode constants and the predecode function used by the
// fetch-to-decode record queue.
package predecode_queue_pkg;

   typedef logic [31:0] addr_t;
   typedef logic [5:0]  opcode_t;
   typedef logic [5:0]  funct_t;
   typedef logic [4:0]  regid_t;

   typedef struct packed {
      opcode_t     opcode;
      regid_t      rA;
      regid_t      rB;
      regid_t      rC;
      logic [4:0]  shamt;
      funct_t      funct;
      logic [31:0] valC;
      addr_t       valP;
      addr_t       pc;
   } plr_d;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } ibus_resp_t;

   localparam opcode_t OP_SPECIAL = 6'h00;
   localparam opcode_t OP_REGIMM  = 6'h01;
   localparam opcode_t OP_J       = 6'h02;
   localparam opcode_t OP_JAL     = 6'h03;
   localparam opcode_t OP_BEQ     = 6'h04;
   localparam opcode_t OP_BNE     = 6'h05;
   localparam opcode_t OP_BLEZ    = 6'h06;
   localparam opcode_t OP_BGTZ    = 6'h07;
   localparam opcode_t OP_ADDIU   = 6'h09;
   localparam opcode_t OP_SLTI    = 6'h0A;
   localparam opcode_t OP_SLTIU   = 6'h0B;
   localparam opcode_t OP_ANDI    = 6'h0C;
   localparam opcode_t OP_ORI     = 6'h0D;
   localparam opcode_t OP_XORI    = 6'h0E;
   localparam opcode_t OP_LUI     = 6'h0F;
   localparam opcode_t OP_LB      = 6'h20;
   localparam opcode_t OP_LH      = 6'h21;
   localparam opcode_t OP_LW      = 6'h23;
   localparam opcode_t OP_LBU     = 6'h24;
   localparam opcode_t OP_LHU     = 6'h25;
   localparam opcode_t OP_SB      = 6'h28;
   localparam opcode_t OP_SH      = 6'h29;
   localparam opcode_t OP_SW      = 6'h2B;

   function automatic plr_d predecode(input logic [31:0] word, input addr_t pc);
      plr_d        r;
      opcode_t     op;
      logic [15:0] imm;
      op       = word[31:26];
      imm      = word[15:0];
      r        = '0;
      r.opcode = op;
      r.pc     = pc;
      r.valP   = pc;
      case (op)
         OP_SPECIAL: begin
            r.rA    = word[25:21];
            r.rB    = word[20:16];
            r.rC    = word[15:11];
            r.shamt = word[10:6];
            r.funct = word[5:0];
         end
         OP_LUI: begin
            r.rB   = word[20:16];
            r.valC = {imm, 16'b0};
         end
         OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
         OP_SB, OP_SH, OP_SW: begin
            r.rA   = word[25:21];
            r.rB   = word[20:16];
            r.valC = {{16{imm[15]}}, imm};
         end
         OP_ANDI, OP_ORI, OP_XORI: begin
            r.rA   = word[25:21];
            r.rB   = word[20:16];
            r.valC = {16'b0, imm};
         end
         OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM: begin
            r.rA   = word[25:21];
            r.rB   = word[20:16];
            r.valC = {{14{imm[15]}}, imm, 2'b00};
         end
         OP_J, OP_JAL: begin
            r.valC = {pc[31:28], word[25:0], 2'b00};
         end
         default: ;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/predecode_queue_pc.sv
// Small FIFO holding the PCs of outstanding instruction-bus requests, in
// issue order, so each response can be paired with its address.
module pc_fifo
   import predecode_queue_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int LW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  addr_t         din,
   output addr_t         dout,
   output logic          empty,
   output logic          full,
   output logic [LW-1:0] level
);

   addr_t         mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          do_pop;
   logic          do_push;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (level == '0);
   assign full    = (level == LW'(DEPTH));
   assign dout    = mem[rd_ptr];
   assign do_pop  = pop & ~empty;
   // A push into a full FIFO is accepted only when a pop frees a slot.
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= bump(wr_ptr);
         end
         if (do_pop) rd_ptr <= bump(rd_ptr);
         level <= level + LW'(do_push) - LW'(do_pop);
      end
   end

endmodule

// File: rtl/predecode_queue.sv
// Registered fetch-to-decode buffer: predecodes bus responses into records,
// queues them for decode and discards wrong-path responses after a flush.
module predecode_queue
   import predecode_queue_pkg::*;
#(
   parameter  int DEPTH   = 4,
   parameter  int MAX_OUT = 2,
   localparam int CW      = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ireq_valid,
   input  addr_t         req_pc,
   input  ibus_resp_t    iresp,
   input  logic          flush,
   input  logic          out_ready,
   output logic          out_valid,
   output plr_d          out,
   output logic          fetch_stall,
   output logic [CW-1:0] count,
   output logic          overflow
);

   localparam int QW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OW = $clog2(MAX_OUT + 1);

   plr_d          mem [DEPTH];
   logic [QW-1:0] head;
   logic [QW-1:0] tail;
   logic [OW-1:0] outstanding;
   logic [OW-1:0] drop_cnt;
   addr_t         resp_pc;
   logic          pc_empty;
   logic          pc_full;
   logic          fire;
   logic          resp;
   logic          live;
   logic          deq;
   logic [31:0]   occupancy;
   plr_d          rec;

   function automatic logic [QW-1:0] bump(input logic [QW-1:0] p);
      return (p == QW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign fire = ireq_valid & iresp.addr_ok;
   assign resp = iresp.data_ok & ~pc_empty;
   assign live = resp & ~flush & (drop_cnt == '0);
   assign deq  = out_valid & out_ready;
   assign rec  = predecode(iresp.data, resp_pc);

   pc_fifo #(.DEPTH(MAX_OUT)) u_pc_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fire),
      .pop   (resp),
      .din   (req_pc),
      .dout  (resp_pc),
      .empty (pc_empty),
      .full  (pc_full),
      .level (outstanding)
   );

   assign out_valid = (count != '0);
   assign out       = out_valid ? mem[head] : '0;
   // Responses still owed to the wrong path never need a slot, so they are
   // subtracted from the reservation.
   assign occupancy   = 32'(count) + 32'(outstanding) - 32'(drop_cnt);
   assign fetch_stall = (occupancy >= 32'(DEPTH)) | (outstanding == OW'(MAX_OUT));

   // A request firing during the flush is new-path, so only the old requests
   // left after this cycle's response are marked for discard.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drop_cnt <= '0;
      end else if (flush) begin
         drop_cnt <= outstanding - OW'(resp);
      end else if (resp && drop_cnt != '0) begin
         drop_cnt <= drop_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (live && count == CW'(DEPTH) && !deq) begin
         overflow <= 1'b1;
      end else begin
         if (live) begin
            mem[tail] <= rec;
            tail      <= bump(tail);
         end
         if (deq) head <= bump(head);
         count <= count + CW'(live) - CW'(deq);
      end
   end

endmodule

// File: tb/tb_predecode_queue.sv
// Directed bench for predecode_queue: fetch, pipelining, fill, flush,
// decode corners, overflow and asynchronous reset.
module tb_predecode_queue;
   import predecode_queue_pkg::*;

   logic       clk;
   logic       reset;
   logic       ireq_valid;
   addr_t      req_pc;
   ibus_resp_t iresp;
   logic       flush;
   logic       out_ready;
   logic       out_valid;
   plr_d       out_rec;
   logic       fetch_stall;
   logic [2:0] count;
   logic       overflow;

   int total = 0;
   int bad   = 0;

   predecode_queue #(.DEPTH(4), .MAX_OUT(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .ireq_valid  (ireq_valid),
      .req_pc      (req_pc),
      .iresp       (iresp),
      .flush       (flush),
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .out         (out_rec),
      .fetch_stall (fetch_stall),
      .count       (count),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [127:0] got,
                              input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ireq_valid    = 1'b0;
      req_pc        = '0;
      iresp.addr_ok = 1'b0;
      iresp.data_ok = 1'b0;
      iresp.data    = '0;
      flush         = 1'b0;
   endtask

   task automatic applyStimulus(input addr_t pc, input logic [31:0] word);
      ireq_valid    = 1'b1;
      iresp.addr_ok = 1'b1;
      req_pc        = pc;
      cycle();
      ireq_valid    = 1'b0;
      iresp.addr_ok = 1'b0;
      iresp.data_ok = 1'b1;
      iresp.data    = word;
      cycle();
      iresp.data_ok = 1'b0;
   endtask

   task automatic fireOnly(input addr_t pc);
      ireq_valid    = 1'b1;
      iresp.addr_ok = 1'b1;
      req_pc        = pc;
      cycle();
      ireq_valid    = 1'b0;
      iresp.addr_ok = 1'b0;
   endtask

   task automatic respOnly(input logic [31:0] word);
      iresp.data_ok = 1'b1;
      iresp.data    = word;
      cycle();
      iresp.data_ok = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      out_ready = 1'b0;
      idle();
      cycle();
      cycle();
      checkOutput("rst_valid", 128'(out_valid), 128'(0));
      checkOutput("rst_count", 128'(count), 128'(0));
      checkOutput("rst_stall", 128'(fetch_stall), 128'(0));
      checkOutput("rst_ovf", 128'(overflow), 128'(0));
      checkOutput("rst_out", 128'(out_rec), 128'(0));
      reset = 1'b0;
      cycle();

      $display("[TB] single fetch");
      applyStimulus(32'hBFC0_0000, 32'h2408_0005);
      checkOutput("t1_valid", 128'(out_valid), 128'(1));
      checkOutput("t1_rA", 128'(out_rec.rA), 128'(0));
      checkOutput("t1_rB", 128'(out_rec.rB), 128'(8));
      checkOutput("t1_valC", 128'(out_rec.valC), 128'(5));
      checkOutput("t1_pc", 128'(out_rec.pc), 128'h0BFC0_0000);
      checkOutput("t1_valP", 128'(out_rec.valP), 128'h0BFC0_0000);
      checkOutput("t1_op", 128'(out_rec.opcode), 128'h09);
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
      checkOutput("t1_drained", 128'(count), 128'(0));
      checkOutput("t1_out_zero", 128'(out_rec), 128'(0));

      $display("[TB] pipelined fetch");
      fireOnly(32'h100);
      checkOutput("t2_stall_1out", 128'(fetch_stall), 128'(0));
      fireOnly(32'h104);
      checkOutput("t2_stall_2out", 128'(fetch_stall), 128'(1));
      respOnly(32'h2409_0001);
      checkOutput("t2_stall_after1", 128'(fetch_stall), 128'(0));
      respOnly(32'h240A_0002);
      checkOutput("t2_count", 128'(count), 128'(2));
      checkOutput("t2_pc0", 128'(out_rec.pc), 128'h100);
      out_ready = 1'b1;
      cycle();
      checkOutput("t2_pc1", 128'(out_rec.pc), 128'h104);
      checkOutput("t2_rB1", 128'(out_rec.rB), 128'(10));
      cycle();
      out_ready = 1'b0;
      checkOutput("t2_empty", 128'(out_valid), 128'(0));

      $display("[TB] fill and decode corners");
      applyStimulus(32'h9000_0000, 32'h0800_0010);
      applyStimulus(32'h304, 32'h1000_FFFF);
      applyStimulus(32'h308, 32'h3400_8000);
      applyStimulus(32'h30C, 32'h3C01_1234);
      checkOutput("t3_count_full", 128'(count), 128'(4));
      checkOutput("t3_stall_full", 128'(fetch_stall), 128'(1));
      checkOutput("t3_ovf", 128'(overflow), 128'(0));
      checkOutput("t3_j_valC", 128'(out_rec.valC), 128'h9000_0040);
      fireOnly(32'h310);
      out_ready     = 1'b1;
      iresp.data_ok = 1'b1;
      iresp.data    = 32'h0022_1820;
      cycle();
      iresp.data_ok = 1'b0;
      checkOutput("t3_count_same", 128'(count), 128'(4));
      checkOutput("t3_ovf_same", 128'(overflow), 128'(0));
      checkOutput("t3_beq_valC", 128'(out_rec.valC), 128'hFFFF_FFFC);
      checkOutput("t3_beq_pc", 128'(out_rec.pc), 128'h304);
      cycle();
      checkOutput("t3_ori_valC", 128'(out_rec.valC), 128'h0000_8000);
      cycle();
      checkOutput("t3_lui_valC", 128'(out_rec.valC), 128'h1234_0000);
      checkOutput("t3_lui_rB", 128'(out_rec.rB), 128'(1));
      cycle();
      checkOutput("t3_r_pc", 128'(out_rec.pc), 128'h310);
      checkOutput("t3_r_regs", 128'({out_rec.rA, out_rec.rB, out_rec.rC}),
                  128'({5'd1, 5'd2, 5'd3}));
      checkOutput("t3_r_funct", 128'(out_rec.funct), 128'h20);
      cycle();
      out_ready = 1'b0;
      checkOutput("t3_drained", 128'(count), 128'(0));

      $display("[TB] flush");
      applyStimulus(32'h400, 32'h2408_0005);
      applyStimulus(32'h404, 32'h2408_0006);
      fireOnly(32'h408);
      fireOnly(32'h40C);
      checkOutput("t4_pre_count", 128'(count), 128'(2));
      flush         = 1'b1;
      iresp.data_ok = 1'b1;
      iresp.data    = 32'h2408_0007;
      ireq_valid    = 1'b1;
      iresp.addr_ok = 1'b1;
      req_pc        = 32'h200;
      cycle();
      idle();
      checkOutput("t4_flush_valid", 128'(out_valid), 128'(0));
      checkOutput("t4_flush_count", 128'(count), 128'(0));
      checkOutput("t4_flush_stall", 128'(fetch_stall), 128'(1));
      respOnly(32'h2408_0008);
      checkOutput("t4_dropped", 128'(out_valid), 128'(0));
      checkOutput("t4_stall_after_drop", 128'(fetch_stall), 128'(0));
      respOnly(32'h2408_0009);
      checkOutput("t4_new_valid", 128'(out_valid), 128'(1));
      checkOutput("t4_new_pc", 128'(out_rec.pc), 128'h200);
      checkOutput("t4_new_valC", 128'(out_rec.valC), 128'(9));
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
      checkOutput("t4_drained", 128'(count), 128'(0));

      $display("[TB] overflow and async reset");
      for (int i = 0; i < 4; i++) applyStimulus(32'h500 + 32'(4 * i), 32'h2408_0001);
      checkOutput("t5_pre_ovf", 128'(overflow), 128'(0));
      applyStimulus(32'h600, 32'h2408_0002);
      checkOutput("t5_ovf_set", 128'(overflow), 128'(1));
      checkOutput("t5_ovf_count", 128'(count), 128'(4));
      checkOutput("t5_ovf_head", 128'(out_rec.pc), 128'h500);
      out_ready = 1'b1;
      cycle();
      cycle();
      out_ready = 1'b0;
      checkOutput("t5_ovf_sticky", 128'(overflow), 128'(1));
      ireq_valid    = 1'b1;
      iresp.addr_ok = 1'b1;
      req_pc        = 32'h700;
      cycle();
      iresp.data_ok = 1'b1;
      iresp.data    = 32'h2408_0003;
      #3;
      reset = 1'b1;
      #1;
      checkOutput("t5_ar_valid", 128'(out_valid), 128'(0));
      checkOutput("t5_ar_count", 128'(count), 128'(0));
      checkOutput("t5_ar_stall", 128'(fetch_stall), 128'(0));
      checkOutput("t5_ar_ovf", 128'(overflow), 128'(0));
      checkOutput("t5_ar_out", 128'(out_rec), 128'(0));
      idle();
      cycle();
      reset = 1'b0;
      cycle();
      checkOutput("t5_post_count", 128'(count), 128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
